// File: rtl/sdram_request_scheduler.sv
// Shares one SDRAM port between NUM_REQ ROM requesters and the IOCTL download path, tagging
// acked reads in order. Define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration.
module sdram_request_scheduler #(
  parameter int unsigned NUM_REQ     = 5,
  parameter int unsigned ADDR_WIDTH  = 23,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_valid,
  input  logic                          dl_active,
  input  logic                          dl_req,
  input  logic [ADDR_WIDTH-1:0]         dl_addr,
  input  logic [DATA_WIDTH-1:0]         dl_data,
  input  logic                          dl_we_en,
  output logic [ADDR_WIDTH-1:0]         sdram_addr,
  output logic [DATA_WIDTH-1:0]         sdram_data,
  output logic                          sdram_we,
  output logic                          sdram_req,
  input  logic                          sdram_ack,
  input  logic                          sdram_valid,
  output logic [$clog2(MAX_PENDING):0]  pending_count,
  output logic                          err_orphan
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = $clog2(MAX_PENDING);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDownload} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IdxW-1:0]       tag_mem [MAX_PENDING];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  err_q;

  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [NUM_REQ-1:0]    one;

  assign one        = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(MAX_PENDING));
  assign push       = (state_q == StIssue) && sdram_ack;
  assign pop        = sdram_valid && !fifo_empty;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[IdxW'(i)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
      end
    end
`else
    // Search starts just above the previous winner and wraps.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [IdxW-1:0] cand;
      cand = IdxW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  always_comb begin
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IdxW'(i)) win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    unique case (state_q)
      StIdle: begin
        if (dl_active) begin
          state_d = StDownload;
        end else if (win_found && !fifo_full) begin
          grant_d = win_idx;
          addr_d  = win_addr;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (sdram_ack) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      StDownload: begin
        if (!dl_active && fifo_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    sdram_req  = (state_q == StIssue);
    sdram_addr = addr_q;
    sdram_data = '0;
    sdram_we   = 1'b0;
    if (state_q == StDownload) begin
      sdram_req  = dl_req;
      sdram_addr = dl_addr;
      sdram_data = dl_data;
      sdram_we   = dl_we_en;
    end
  end

  assign req_ack       = push ? (one << grant_q) : '0;
  assign req_valid     = pop ? (one << tag_mem[rd_ptr_q]) : '0;
  assign pending_count = count_q;
  assign err_orphan    = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_PENDING; i++) tag_mem[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        tag_mem[wr_ptr_q] <= grant_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (sdram_valid && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule
